// File: rtl/ibex_mem_pkg.sv
// Shared types and constants for the Ibex memory responder.
package ibex_mem_pkg;

    typedef struct packed {
        logic        err;
        logic [31:0] rdata;
    } mem_resp_t;

    localparam int unsigned MEM_WORD_BYTES   = 4;
    localparam int unsigned MAX_RESP_LATENCY = 4;
    localparam int unsigned MEM_RESP_W       = $bits(mem_resp_t);

    // Counter must be able to hold the value MAX_OUTSTANDING itself.
    function automatic int unsigned outstanding_width(input int unsigned max_outstanding);
        return $clog2(max_outstanding + 1);
    endfunction

endpackage

// File: rtl/ibex_mem_resp_pipe.sv
// Fixed-latency response delay line: DEPTH stages of {valid, mem_resp_t}.
// Synchronous active-low clear empties every stage.
module ibex_mem_resp_pipe
    import ibex_mem_pkg::*;
#(
    parameter int unsigned DEPTH = 1
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  valid_i,
    input  logic [MEM_RESP_W-1:0] resp_i,
    output logic                  valid_o,
    output logic [MEM_RESP_W-1:0] resp_o
);

    logic [DEPTH-1:0]      valid_q;
    logic [MEM_RESP_W-1:0] resp_q [DEPTH];

    // Shift one stage per cycle; clearing the payload keeps idle outputs at zero.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            valid_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                resp_q[i] <= '0;
            end
        end else begin
            valid_q[0] <= valid_i;
            resp_q[0]  <= resp_i;
            for (int i = 1; i < int'(DEPTH); i++) begin
                valid_q[i] <= valid_q[i-1];
                resp_q[i]  <= resp_q[i-1];
            end
        end
    end

    assign valid_o = valid_q[DEPTH-1];
    assign resp_o  = resp_q[DEPTH-1];

endmodule

// File: rtl/ibex_mem_responder.sv
// Memory-side responder for the Ibex req/gnt/rvalid interface, backed by a
// word-addressed SRAM with byte-enable writes and fixed response latency.
// Optional feature: define IBEX_MEM_RESP_STALL_EN to insert WAIT_CYCLES wait
// states before each grant.
module ibex_mem_responder
    import ibex_mem_pkg::*;
#(
    parameter int unsigned MEM_WORDS       = 1024,
    parameter logic [31:0] BASE_ADDR       = 32'h0001_0000,
    parameter int unsigned RESP_LATENCY    = 1,
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter int unsigned WAIT_CYCLES     = 2
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        req_i,
    output logic        gnt_o,
    output logic        rvalid_o,
    input  logic        we_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic        err_o
);

    localparam int unsigned      IDX_W   = $clog2(MEM_WORDS);
    localparam int unsigned      OUT_W   = outstanding_width(MAX_OUTSTANDING);
    localparam logic [OUT_W-1:0] MAX_OUT = OUT_W'(MAX_OUTSTANDING);
    // One past the last valid byte, kept at 33 bits so the top of memory cannot wrap.
    localparam logic [32:0]      END_ADDR = {1'b0, BASE_ADDR} + 33'(MEM_WORD_BYTES * MEM_WORDS);

    // Elaboration-time parameter sanity checks.
    if (RESP_LATENCY < 1 || RESP_LATENCY > MAX_RESP_LATENCY) begin : g_bad_latency
        $error("RESP_LATENCY out of range");
    end
    if (MAX_OUTSTANDING < 1 || MAX_OUTSTANDING > 4) begin : g_bad_outstanding
        $error("MAX_OUTSTANDING out of range");
    end
    if (MEM_WORDS < 2 || (MEM_WORDS & (MEM_WORDS - 1)) != 0) begin : g_bad_depth
        $error("MEM_WORDS must be a power of two and at least 2");
    end
    if (WAIT_CYCLES > 255) begin : g_bad_wait
        $error("WAIT_CYCLES too large for the wait counter");
    end

    logic [31:0]      mem [MEM_WORDS];
    logic             in_range;
    logic [IDX_W-1:0] idx;
    logic             slot_free;
    logic             wait_done;
    logic [OUT_W-1:0] outstanding_q, outstanding_d;
    mem_resp_t        resp_in;
    logic [MEM_RESP_W-1:0] pipe_resp;
    mem_resp_t        resp_out;

    // Address decode: range check at full width, word index relative to BASE_ADDR.
    always_comb begin
        in_range = (addr_i >= BASE_ADDR) && ({1'b0, addr_i} < END_ADDR);
        idx      = IDX_W'((addr_i - BASE_ADDR) >> 2);
    end

    // A retiring response frees its slot in the same cycle.
    assign slot_free = (outstanding_q < MAX_OUT) || rvalid_o;
    assign gnt_o     = req_i && rstn && slot_free && wait_done;

`ifdef IBEX_MEM_RESP_STALL_EN
    localparam int unsigned       WAIT_W   = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(WAIT_CYCLES);

    logic [WAIT_W-1:0] wait_q, wait_d;

    assign wait_done = (wait_q >= WAIT_MAX);

    // Count request-high cycles; restart after each grant or when req_i drops.
    always_comb begin
        wait_d = wait_q;
        if (!req_i || gnt_o) begin
            wait_d = '0;
        end else if (!wait_done) begin
            wait_d = wait_q + 1'b1;
        end
    end

    // Wait counter register.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            wait_q <= '0;
        end else begin
            wait_q <= wait_d;
        end
    end
`else
    assign wait_done = 1'b1;
`endif

    // Outstanding count: +1 on grant, -1 on retire, unchanged when both coincide.
    always_comb begin
        outstanding_d = outstanding_q;
        if (gnt_o && !rvalid_o) begin
            outstanding_d = outstanding_q + 1'b1;
        end else if (!gnt_o && rvalid_o) begin
            outstanding_d = outstanding_q - 1'b1;
        end
    end

    // Outstanding counter register.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            outstanding_q <= '0;
        end else begin
            outstanding_q <= outstanding_d;
        end
    end

    // SRAM write port; contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (gnt_o && we_i && in_range) begin
            for (int k = 0; k < 4; k++) begin
                if (be_i[k]) begin
                    mem[idx][8*k +: 8] <= wdata_i[8*k +: 8];
                end
            end
        end
    end

    // Build the response at grant time; zero payload whenever nothing is granted.
    always_comb begin
        resp_in = '0;
        if (gnt_o) begin
            resp_in.err = !in_range;
            if (in_range && !we_i) begin
                resp_in.rdata = mem[idx];
            end
        end
    end

    ibex_mem_resp_pipe #(
        .DEPTH (RESP_LATENCY)
    ) u_resp_pipe (
        .clk     (clk),
        .rstn    (rstn),
        .valid_i (gnt_o),
        .resp_i  (resp_in),
        .valid_o (rvalid_o),
        .resp_o  (pipe_resp)
    );

    assign resp_out = mem_resp_t'(pipe_resp);
    assign rdata_o  = resp_out.rdata;
    assign err_o    = resp_out.err;

endmodule
